// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: time-multiplexed fully-connected neuron.
// One signed multiplier and one wide accumulator are shared across a run of
// `len` serial inputs. Each accepted x is multiplied by the weight read
// combinationally at w_addr. After the last product has been accumulated,
// the bias is added. The sum is then rescaled to the Q format, saturated, and
// optionally passed through ReLU.
//
// Ports:
//   clk, rst_n              clock (rising edge) / async active-low reset
//   start, len, bias, relu_en  run request; sampled only when idle
//   busy                    high from accepted start until the y handshake
//   x_data/x_valid/x_ready  serial input activation stream
//   w_addr/w_data           weight regfile read (same-cycle data)
//   y_data/y_valid/y_ready  result, held until accepted
module neuron_mac_seq #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int N_MAX  = 784,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = $clog2(N_MAX+1),
  parameter int ADDR_W = $clog2(N_MAX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [DATA_W-1:0] bias,
  input  logic              relu_en,
  output logic              busy,
  input  logic [DATA_W-1:0] x_data,
  input  logic              x_valid,
  output logic              x_ready,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] y_data,
  output logic              y_valid,
  input  logic              y_ready
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_e;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           len_q, len_d, idx_q, idx_d;
  logic [DATA_W-1:0]          bias_q, bias_d, y_q, y_d;
  logic                       relu_q, relu_d;
  logic signed [2*DATA_W-1:0] p_q, p_d;
  logic                       p_vld_q, p_vld_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;

  logic [CNT_W-1:0]           len_clamp;
  logic signed [2*DATA_W-1:0] xs, ws, prod;
  logic signed [ACC_W-1:0]    sum, s, sat;
  logic [DATA_W-1:0]          y_out;
  logic                       unused_sat_hi;

  // Datapath: multiplier, then rescale/saturate/ReLU of the settled accumulator.
  always_comb begin
    len_clamp = (len > CNT_W'(N_MAX)) ? CNT_W'(N_MAX) : len;
    xs   = (2*DATA_W)'($signed(x_data));
    ws   = (2*DATA_W)'($signed(w_data));
    prod = xs * ws;
    sum  = acc_q + (ACC_W'($signed(bias_q)) <<< FRAC_W);
    s    = sum >>> FRAC_W;   // arithmetic: floor toward -inf
    if (s > SAT_MAX)      sat = SAT_MAX;
    else if (s < SAT_MIN) sat = SAT_MIN;
    else                  sat = s;
    y_out = (relu_q && sat[DATA_W-1]) ? '0 : sat[DATA_W-1:0];
  end

  // Above DATA_W the saturated value is pure sign extension.
  assign unused_sat_hi = ^sat[ACC_W-1:DATA_W];

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bias_d  = bias_q;
    relu_d  = relu_q;
    y_d     = y_q;
    p_d     = p_q;
    p_vld_d = 1'b0;
    acc_d   = p_vld_q ? acc_q + ACC_W'(p_q) : acc_q;

    case (state_q)
      IDLE: if (start) begin
        len_d   = len_clamp;
        bias_d  = bias;
        relu_d  = relu_en;
        acc_d   = '0;
        idx_d   = '0;
        state_d = (len_clamp != '0) ? ACCUM : DRAIN;
      end
      ACCUM: if (x_valid) begin
        p_d     = prod;
        p_vld_d = 1'b1;
        idx_d   = idx_q + CNT_W'(1);
        if (idx_q == len_q - CNT_W'(1)) state_d = DRAIN;
      end
      // Wait here until the product register is empty, so acc_q holds the
      // complete sum when the output is registered.
      DRAIN: if (!p_vld_q) begin
        y_d     = y_out;
        state_d = OUT;
      end
      OUT: if (y_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bias_q  <= '0;
      relu_q  <= 1'b0;
      y_q     <= '0;
      p_q     <= '0;
      p_vld_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bias_q  <= bias_d;
      relu_q  <= relu_d;
      y_q     <= y_d;
      p_q     <= p_d;
      p_vld_q <= p_vld_d;
      acc_q   <= acc_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign x_ready = (state_q == ACCUM);
  assign y_valid = (state_q == OUT);
  assign y_data  = y_q;
  assign w_addr  = ADDR_W'(idx_q);

endmodule
